aes_top_inv_cipher: RTL and testbench
=====================================

AES_TOP_INV_CIPHER -- requirements
Module: aes_top_inv_cipher

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk input, rst input.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous active-low reset; asserting it clears all state immediately.
REQ-004 in_valid  input  1  request valid; in_ready  output  1  request accepted when in_valid and in_ready are both high.
REQ-005 key_in  input  128  decryption key, sampled on accept.
REQ-006 ct_in  input  128  ciphertext, sampled on accept.
REQ-007 out_valid  output  1  result valid; out_ready  input  1  result consumed when both are high.
REQ-008 pt_out  output  128  recovered plaintext.
REQ-009 st_done  output  1  self-test complete; st_fail  output  1  self-test mismatch, sticky.
REQ-010 The block SHALL instantiate aes_inv_cipher with ports (clk, rst, kld, ld, done, key, text_in, text_out, kdone), and SHALL drive only kld, ld, key and text_in.

Function
REQ-011 FSM states: ST_SELF, IDLE, KEXP, LOAD, RUN, HOLD.
REQ-012 IDLE: in_ready=1, all other handshake outputs 0.
REQ-013 Accept in IDLE, key cached and key_in equal to the cached key: register ct_in and go to LOAD, skipping key expansion.
REQ-014 Accept in IDLE otherwise: register key_in into key_reg, pulse kld high for exactly 1 cycle, clear the cache flag, and go to KEXP.
REQ-015 KEXP: wait for kdone=1, then set the cache flag and go to LOAD.
REQ-016 LOAD: pulse ld high for exactly 1 cycle with text_in = the registered ciphertext, then go to RUN.
REQ-017 RUN: on done=1, capture text_out into pt_out and go to HOLD with out_valid=1 in the next cycle.
REQ-018 HOLD: out_valid and pt_out SHALL stay stable until out_ready=1; on that cycle, clear out_valid and go to IDLE.
REQ-019 in_ready SHALL be 0 in every state except IDLE; no second request is accepted until the result is consumed.
REQ-020 in_valid held high while in_ready=0 SHALL be ignored, and inputs SHALL NOT be sampled.
REQ-021 key and text_in to the core SHALL come only from registers, never combinationally from key_in or ct_in.
REQ-022 A kld or ld pulse SHALL never occur while the core is busy (KEXP or RUN).
REQ-023 out_ready high while out_valid=0 SHALL have no effect.
REQ-024 Accept and consume in the same cycle cannot occur, because IDLE and HOLD are distinct states; consume-to-next-accept is at least 1 cycle.

Reset
REQ-025 While rst=0: FSM = ST_SELF (macro defined) or IDLE (macro undefined); cache flag 0; key_reg and ct register 0; pt_out 0; out_valid 0; kld 0; ld 0.
REQ-026 While rst=0, in_ready SHALL be 0.
REQ-027 While rst=0, st_fail SHALL be 0.
REQ-028 While rst=0, st_done SHALL be 0 with the macro and 1 without it.
REQ-029 Reset asserted mid-operation (KEXP, RUN or HOLD) SHALL abort the operation with no output pulse, and SHALL invalidate the cache.

Configuration
REQ-030 Macro AES_INV_SELFTEST_EN defined: after reset, ST_SELF SHALL run one known-answer decryption through the same KEXP/LOAD/RUN path, with no handshake.
REQ-031 Known-answer vector: key 2b7e151628aed2a6abf7158809cf4f3c, ciphertext 3925841d02dc09fbdc118597196a0b32; expected plaintext 3243f6a8885a308d313198a2e0370734.
REQ-032 When the self-test finishes: st_done=1; st_fail=1 if the result mismatches; then go to IDLE with the key cached; out_valid stays 0 throughout.
REQ-033 Macro AES_INV_SELFTEST_EN undefined: no ST_SELF logic; st_done tied 1; st_fail tied 0.

Verification
REQ-034 FIPS-197 vector (REQ-031) in one request -> kld pulse, kdone wait, ld pulse; pt_out=3243f6a8885a308d313198a2e0370734 with out_valid=1.
REQ-035 Second request with the same key and the same ciphertext -> no kld pulse; identical pt_out; latency shorter by the key-expansion time.
REQ-036 out_ready held 0 for 20 cycles -> out_valid and pt_out stable for all 20 cycles; in_valid pulses ignored; in_ready=0.
REQ-037 rst driven low during RUN -> out_valid=0 throughout; next request with the same key SHALL pulse kld (cache cleared).
REQ-038 Macro defined, reset released -> st_done rises with st_fail=0 and in_ready=1; a subsequent REQ-031 request issues no kld.
REQ-039 Macro defined, core forced to a corrupted result -> st_fail=1 and remains 1 until reset.

Source files
------------

// File: rtl/aes_top_inv_cipher.sv
// AES-128 inverse cipher wrapper: ready/valid front end, key-schedule cache and an iterative decrypt core.
// Optional power-up known-answer self-test is enabled by defining AES_INV_SELFTEST_EN.
module aes_inv_cipher (
    input  logic         clk,
    input  logic         rst,
    input  logic         kld,
    input  logic         ld,
    output logic         done,
    input  logic [127:0] key,
    input  logic [127:0] text_in,
    output logic [127:0] text_out,
    output logic         kdone
);
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    // x^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0 as the S-box needs.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] y, r;
        y = x;
        r = 8'h01;
        for (int i = 0; i < 7; i++) begin
            y = gmul(y, y);
            r = gmul(r, y);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] b;
        b = gf_inv(x);
        return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        return gf_inv(rotl(s, 1) ^ rotl(s, 3) ^ rotl(s, 6) ^ 8'h05);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1: return 8'h01;  4'd2: return 8'h02;  4'd3: return 8'h04;
            4'd4: return 8'h08;  4'd5: return 8'h10;  4'd6: return 8'h20;
            4'd7: return 8'h40;  4'd8: return 8'h80;  4'd9: return 8'h1b;
            default: return 8'h36;
        endcase
    endfunction

    function automatic logic [31:0] sub_rot(input logic [31:0] w);
        return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
    endfunction

    function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] n0, n1, n2, n3;
        n0 = k[127:96] ^ sub_rot(k[31:0]) ^ {rc, 24'h0};
        n1 = k[95:64] ^ n0;
        n2 = k[63:32] ^ n1;
        n3 = k[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    // Walks the schedule backwards so only the last round key has to be stored.
    function automatic logic [127:0] prev_key(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] p0, p1, p2, p3;
        p3 = k[31:0] ^ k[63:32];
        p2 = k[63:32] ^ k[95:64];
        p1 = k[95:64] ^ k[127:96];
        p0 = k[127:96] ^ sub_rot(p3) ^ {rc, 24'h0};
        return {p0, p1, p2, p3};
    endfunction

    function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127 - 8 * (r + 4 * c) -: 8] = inv_sbox(s[127 - 8 * (r + 4 * ((c - r + 4) % 4)) -: 8]);
        return o;
    endfunction

    function automatic logic [127:0] inv_mix(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32 * c -: 8];
            a1 = s[119 - 32 * c -: 8];
            a2 = s[111 - 32 * c -: 8];
            a3 = s[103 - 32 * c -: 8];
            o[127 - 32 * c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
            o[119 - 32 * c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
            o[111 - 32 * c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
            o[103 - 32 * c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
        end
        return o;
    endfunction

    logic [127:0] kw, st, rk, ark;
    logic [3:0]   kcnt, rnd;
    logic         kbusy, dbusy;

    assign ark = inv_shift_sub(st) ^ rk;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            kw <= '0; st <= '0; rk <= '0; text_out <= '0;
            kcnt <= '0; rnd <= '0; kbusy <= 1'b0; dbusy <= 1'b0;
            kdone <= 1'b0; done <= 1'b0;
        end else begin
            kdone <= 1'b0;
            done  <= 1'b0;
            if (kld) begin
                kw <= key; kcnt <= 4'd1; kbusy <= 1'b1;
            end else if (kbusy) begin
                kw   <= next_key(kw, rcon(kcnt));
                kcnt <= kcnt + 4'd1;
                if (kcnt == 4'd10) begin
                    kbusy <= 1'b0; kdone <= 1'b1;
                end
            end
            if (ld) begin
                st <= text_in ^ kw; rk <= prev_key(kw, rcon(4'd10));
                rnd <= 4'd9; dbusy <= 1'b1;
            end else if (dbusy) begin
                if (rnd != 4'd0) begin
                    st <= inv_mix(ark); rk <= prev_key(rk, rcon(rnd)); rnd <= rnd - 4'd1;
                end else begin
                    text_out <= ark; done <= 1'b1; dbusy <= 1'b0;
                end
            end
        end
    end
endmodule

module aes_top_inv_cipher (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] key_in,
    input  logic [127:0] ct_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] pt_out,
    output logic         st_done,
    output logic         st_fail
);
    typedef enum logic [2:0] {ST_SELF, IDLE, KEXP, LOAD, RUN, HOLD} state_t;

    localparam logic [127:0] KAT_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KAT_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KAT_PT  = 128'h3243f6a8885a308d313198a2e0370734;
`ifdef AES_INV_SELFTEST_EN
    localparam state_t RESET_STATE = ST_SELF;
`else
    localparam state_t RESET_STATE = IDLE;
`endif

    state_t       state, state_n;
    logic [127:0] key_reg, ct_reg, text_out;
    logic         cached, kld, ld, done, kdone, accept, hit, self_run;

    aes_inv_cipher u_core (
        .clk      (clk),
        .rst      (rst),
        .kld      (kld),
        .ld       (ld),
        .done     (done),
        .key      (key_reg),
        .text_in  (ct_reg),
        .text_out (text_out),
        .kdone    (kdone)
    );

    assign in_ready = rst && (state == IDLE);

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        state_n = state;
        accept  = 1'b0;
        hit     = 1'b0;
        case (state)
`ifdef AES_INV_SELFTEST_EN
            ST_SELF: state_n = KEXP;
`endif
            IDLE: if (in_valid) begin
                accept  = 1'b1;
                hit     = cached && (key_in == key_reg);
                state_n = hit ? LOAD : KEXP;
            end
            KEXP:    if (kdone) state_n = LOAD;
            LOAD:    state_n = RUN;
            RUN:     if (done) state_n = self_run ? IDLE : HOLD;
            HOLD:    if (out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RESET_STATE; cached <= 1'b0; key_reg <= '0; ct_reg <= '0;
            pt_out <= '0; out_valid <= 1'b0; kld <= 1'b0; ld <= 1'b0;
        end else begin
            state <= state_n;
            kld   <= 1'b0;
            ld    <= (state_n == LOAD);
            if (accept) begin
                ct_reg <= ct_in;
                if (!hit) begin
                    key_reg <= key_in; kld <= 1'b1; cached <= 1'b0;
                end
            end
`ifdef AES_INV_SELFTEST_EN
            if (state == ST_SELF) begin
                key_reg <= KAT_KEY; ct_reg <= KAT_CT; kld <= 1'b1;
            end
`endif
            if (state == KEXP && kdone) cached <= 1'b1;
            if (state == RUN && done && !self_run) begin
                pt_out <= text_out; out_valid <= 1'b1;
            end
            if (state == HOLD && out_ready) out_valid <= 1'b0;
        end
    end

`ifdef AES_INV_SELFTEST_EN
    logic st_done_r, st_fail_r;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            self_run <= 1'b0; st_done_r <= 1'b0; st_fail_r <= 1'b0;
        end else begin
            if (state == ST_SELF) self_run <= 1'b1;
            if (state == RUN && done && self_run) begin
                self_run  <= 1'b0;
                st_done_r <= 1'b1;
                if (text_out != KAT_PT) st_fail_r <= 1'b1;
            end
        end
    end

    assign st_done = st_done_r;
    assign st_fail = st_fail_r;
`else
    assign self_run = 1'b0;
    assign st_done  = 1'b1;
    assign st_fail  = 1'b0;
`endif
endmodule

// File: tb/tb_aes_top_inv_cipher.sv
// Directed bench for aes_top_inv_cipher: FIPS-197 vectors, key cache, backpressure and mid-run reset.
// Self-test steps are compiled in when AES_INV_SELFTEST_EN is defined.
module tb_aes_top_inv_cipher;
    localparam logic [127:0] KAT_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KAT_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KAT_PT  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C1_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT   = 128'h00112233445566778899aabbccddeeff;
`ifdef AES_INV_SELFTEST_EN
    localparam logic RST_ST_DONE = 1'b0;
`else
    localparam logic RST_ST_DONE = 1'b1;
`endif

    logic         clk = 1'b0, rst = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [127:0] key_in = '0, ct_in = '0;
    logic         in_ready, out_valid, st_done, st_fail;
    logic [127:0] pt_out;
    int           errors = 0, checks = 0, kld_cnt = 0, ld_cnt = 0;

    aes_top_inv_cipher dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .key_in    (key_in),
        .ct_in     (ct_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pt_out    (pt_out),
        .st_done   (st_done),
        .st_fail   (st_fail)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (dut.kld) kld_cnt++;
        if (dut.ld) ld_cnt++;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input logic [127:0] k, input logic [127:0] c, output int lat);
        int n;
        @(negedge clk);
        key_in = k; ct_in = c; in_valid = 1'b1;
        n = 0;
        while (in_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("accept_in_time", 128'(n < 100), 128'd1);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check("result_in_time", 128'(lat < 200), 128'd1);
    endtask

    task automatic consume();
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("consume_clears_valid", 128'(out_valid), 128'd0);
    endtask

    initial begin
        int lat1, lat2, lat3, k0, l0, n;

        repeat (3) @(negedge clk);
        check("rst_in_ready", 128'(in_ready), 128'd0);
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_pt_out", pt_out, 128'd0);
        check("rst_st_done", 128'(st_done), 128'(RST_ST_DONE));
        check("rst_st_fail", 128'(st_fail), 128'd0);
        rst = 1'b1;

`ifdef AES_INV_SELFTEST_EN
        n = 0;
        while (st_done !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("selftest_done", 128'(st_done), 128'd1);
        check("selftest_pass", 128'(st_fail), 128'd0);
        @(negedge clk);
        check("selftest_idle_ready", 128'(in_ready), 128'd1);
        check("selftest_no_out", 128'(out_valid), 128'd0);
        k0 = kld_cnt;
        do_req(KAT_KEY, KAT_CT, lat3);
        check("selftest_cache_kld", 128'(kld_cnt - k0), 128'd0);
        check("selftest_cache_pt", pt_out, KAT_PT);
        consume();
`endif

        @(negedge clk);
        check("idle_in_ready", 128'(in_ready), 128'd1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("stray_out_ready_valid", 128'(out_valid), 128'd0);
        check("stray_out_ready_ready", 128'(in_ready), 128'd1);

        k0 = kld_cnt;
        do_req(C1_KEY, C1_CT, lat3);
        check("c1_pt", pt_out, C1_PT);
        check("c1_kld", 128'(kld_cnt - k0), 128'd1);
        consume();

        k0 = kld_cnt; l0 = ld_cnt;
        do_req(KAT_KEY, KAT_CT, lat1);
        check("kat_pt", pt_out, KAT_PT);
        check("kat_kld", 128'(kld_cnt - k0), 128'd1);
        check("kat_ld", 128'(ld_cnt - l0), 128'd1);

        l0 = ld_cnt;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            in_valid = i[0];
            ct_in = ~KAT_CT;
            check("hold_valid", 128'(out_valid), 128'd1);
            check("hold_pt", pt_out, KAT_PT);
            check("hold_in_ready", 128'(in_ready), 128'd0);
        end
        in_valid = 1'b0;
        check("hold_no_ld", 128'(ld_cnt - l0), 128'd0);
        consume();

        k0 = kld_cnt;
        do_req(KAT_KEY, KAT_CT, lat2);
        check("cached_pt", pt_out, KAT_PT);
        check("cached_no_kld", 128'(kld_cnt - k0), 128'd0);
        check("cached_faster", 128'(lat1 - lat2 >= 10), 128'd1);
        consume();

        l0 = ld_cnt;
        @(negedge clk);
        key_in = KAT_KEY; ct_in = KAT_CT; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (ld_cnt == l0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("abort_reached_run", 128'(ld_cnt - l0), 128'd1);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (i == 4) rst = 1'b1;
            check("abort_no_valid", 128'(out_valid), 128'd0);
        end
        k0 = kld_cnt;
        do_req(KAT_KEY, KAT_CT, lat3);
        check("abort_cache_cleared", 128'(kld_cnt - k0), 128'd1);
        check("abort_next_pt", pt_out, KAT_PT);
        consume();

`ifdef AES_INV_SELFTEST_EN
        force dut.u_core.text_out = 128'd0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        n = 0;
        while (st_done !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("corrupt_done", 128'(st_done), 128'd1);
        check("corrupt_fail", 128'(st_fail), 128'd1);
        release dut.u_core.text_out;
        repeat (10) @(negedge clk);
        check("corrupt_fail_sticky", 128'(st_fail), 128'd1);
        check("corrupt_no_out", 128'(out_valid), 128'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
